// File: rtl/data_array_pkg.sv
// Shared types and width helpers for the way-associative data array.
package data_array_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // Line width in bits for a line of 2**s_offset bytes.
    function automatic int line_w(input int s_offset);
        return 8 * (1 << s_offset);
    endfunction

    // One byte-enable bit per byte of the line.
    function automatic int mask_w(input int s_offset);
        return 1 << s_offset;
    endfunction

    // Number of fill beats needed to cover one line.
    function automatic int beats(input int s_offset, input int beat_w);
        return line_w(s_offset) / beat_w;
    endfunction

endpackage

// File: rtl/way_bank.sv
// Storage for one way: NUM_SETS lines, byte-enable write, async read of
// the current contents, synchronous clear of every line.
module way_bank
    import data_array_pkg::*;
#(
    parameter int S_INDEX = 3,
    parameter int LINE_W  = 256,
    parameter int MASK_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MASK_W-1:0]  wr_be,
    input  logic [S_INDEX-1:0] wr_index,
    input  logic [LINE_W-1:0]  wr_data,
    input  logic [S_INDEX-1:0] rd_index,
    output logic [LINE_W-1:0]  rd_line
);
    localparam int NUM_SETS = 1 << S_INDEX;

    logic [NUM_SETS-1:0][LINE_W-1:0] mem;

    // Clear all lines on reset, otherwise update only the enabled bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '0;
        end else begin
            for (int i = 0; i < MASK_W; i++) begin
                if (wr_be[i]) mem[wr_index][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    assign rd_line = mem[rd_index];

endmodule

// File: rtl/way_data_array.sv
// Way-associative data array with registered reads, byte-masked CPU
// writes and a beat-wise line fill engine. CPU writes and fill beats share
// one write port; CPU writes are refused while a fill is in progress.
// Reads are write-first per byte against that shared port.
// Optional macro DATA_ARRAY_PARITY_EN adds per-byte even parity, the
// par_flip error-injection input and a live rd_perr.
module way_data_array
    import data_array_pkg::*;
#(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 2,
    parameter int BEAT_W   = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rd_en,
    input  logic [S_INDEX-1:0]              rd_index,
    input  logic [$clog2(NUM_WAYS)-1:0]     rd_way,
    output logic [line_w(S_OFFSET)-1:0]     rd_data,
    output logic                            rd_valid,
    input  logic [mask_w(S_OFFSET)-1:0]     wr_mask,
    input  logic [S_INDEX-1:0]              wr_index,
    input  logic [$clog2(NUM_WAYS)-1:0]     wr_way,
    input  logic [line_w(S_OFFSET)-1:0]     wr_data,
    output logic                            wr_ready,
    input  logic                            fill_start,
    input  logic [S_INDEX-1:0]              fill_index,
    input  logic [$clog2(NUM_WAYS)-1:0]     fill_way,
    input  logic                            fill_beat_valid,
    input  logic [BEAT_W-1:0]               fill_beat_data,
    output logic                            fill_busy,
    output logic                            fill_done,
`ifdef DATA_ARRAY_PARITY_EN
    input  logic                            par_flip,
`endif
    output logic                            rd_perr
);
    localparam int LINE_W   = line_w(S_OFFSET);
    localparam int MASK_W   = mask_w(S_OFFSET);
    localparam int BEATS    = beats(S_OFFSET, BEAT_W);
    localparam int WAY_W    = $clog2(NUM_WAYS);
    localparam int CNT_W    = $clog2(BEATS);
    localparam int BEAT_B   = BEAT_W / 8;

    fill_state_t        state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [S_INDEX-1:0] f_index;
    logic [WAY_W-1:0]   f_way;
    logic               beat_take, last_beat;

    // Shared write port seen by the banks and by the read bypass.
    logic [MASK_W-1:0]  w_be;
    logic [S_INDEX-1:0] w_index;
    logic [WAY_W-1:0]   w_way;
    logic [LINE_W-1:0]  w_data;

    logic [NUM_WAYS-1:0][MASK_W-1:0] bank_be;
    logic [NUM_WAYS-1:0][LINE_W-1:0] bank_line;
    logic [LINE_W-1:0]  rd_line_next;
    logic               rd_hit;

    assign fill_busy = (state == FILL);
    assign wr_ready  = ~fill_busy;
    assign beat_take = fill_busy & fill_beat_valid;
    assign last_beat = beat_take & (cnt == CNT_W'(BEATS - 1));

    // Fill state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Fill next-state: start in IDLE, return after the last beat.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (fill_start) state_next = FILL;
            FILL: if (last_beat)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Fill target latch, beat counter and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            f_index   <= '0;
            f_way     <= '0;
            fill_done <= 1'b0;
        end else begin
            fill_done <= last_beat;
            if (state == IDLE && fill_start) begin
                cnt     <= '0;
                f_index <= fill_index;
                f_way   <= fill_way;
            end else if (beat_take) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Write port mux: a fill beat owns the port; otherwise an accepted CPU write.
    always_comb begin
        w_be    = '0;
        w_index = wr_index;
        w_way   = wr_way;
        w_data  = wr_data;
        if (beat_take) begin
            w_index = f_index;
            w_way   = f_way;
            w_data  = {BEATS{fill_beat_data}};
            for (int i = 0; i < MASK_W; i++) w_be[i] = ((i / BEAT_B) == int'(cnt));
        end else if (wr_ready) begin
            w_be = wr_mask;
        end
    end

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
        assign bank_be[g] = (w_way == WAY_W'(g)) ? w_be : '0;
        way_bank #(
            .S_INDEX (S_INDEX),
            .LINE_W  (LINE_W),
            .MASK_W  (MASK_W)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .wr_be    (bank_be[g]),
            .wr_index (w_index),
            .wr_data  (w_data),
            .rd_index (rd_index),
            .rd_line  (bank_line[g])
        );
    end

    // Read line with per-byte write-first bypass from the shared write port.
    always_comb begin
        rd_hit       = (w_index == rd_index) && (w_way == rd_way);
        rd_line_next = bank_line[rd_way];
        for (int i = 0; i < MASK_W; i++) begin
            if (rd_hit && w_be[i]) rd_line_next[i*8 +: 8] = w_data[i*8 +: 8];
        end
    end

    // Registered read port; data holds while no read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_line_next;
        end
    end

`ifdef DATA_ARRAY_PARITY_EN
    logic [NUM_WAYS-1:0][(1<<S_INDEX)-1:0][MASK_W-1:0] par_mem;
    logic [MASK_W-1:0] w_par, rd_par_next;
    logic              perr_next;

    // Parity to store per written byte, and the checked parity of the read line.
    always_comb begin
        rd_par_next = par_mem[rd_way][rd_index];
        perr_next   = 1'b0;
        for (int i = 0; i < MASK_W; i++) begin
            w_par[i] = (^w_data[i*8 +: 8]) ^ par_flip;
            if (rd_hit && w_be[i]) rd_par_next[i] = w_par[i];
            perr_next = perr_next | (rd_par_next[i] ^ (^rd_line_next[i*8 +: 8]));
        end
    end

    // Parity storage, cleared with the data array.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_mem <= '0;
        end else begin
            for (int i = 0; i < MASK_W; i++) begin
                if (w_be[i]) par_mem[w_way][w_index][i] <= w_par[i];
            end
        end
    end

    // Parity error registered alongside rd_data.
    always_ff @(posedge clk) begin
        if (rst)        rd_perr <= 1'b0;
        else if (rd_en) rd_perr <= perr_next;
    end
`else
    assign rd_perr = 1'b0;
`endif

endmodule

// File: doc/way_data_array.md
WAY_DATA_ARRAY -- requirements
Module: way_data_array

Interface
REQ-001 Parameter S_OFFSET, default 5: log2 line bytes; LINE_W = 8*2**S_OFFSET bits, MASK_W = 2**S_OFFSET.
REQ-002 Parameter S_INDEX, default 3: log2 sets; NUM_SETS = 2**S_INDEX.
REQ-003 Parameter NUM_WAYS, default 2, power of two, at least 2; WAY_W = log2(NUM_WAYS).
REQ-004 Parameter BEAT_W, default 64: fill beat width; BEATS = LINE_W/BEAT_W, at least 2, power of two.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 rd_en  in  1  read request.
REQ-008 rd_index  in  S_INDEX  read set; rd_way  in  WAY_W  read way.
REQ-009 rd_data  out  LINE_W  registered read line; rd_valid  out  1  rd_data valid.
REQ-010 wr_mask  in  MASK_W  byte write enables; zero means no write.
REQ-011 wr_index  in  S_INDEX; wr_way  in  WAY_W; wr_data  in  LINE_W.
REQ-012 wr_ready  out  1  write accepted; equals not fill_busy.
REQ-013 fill_start  in  1; fill_index  in  S_INDEX; fill_way  in  WAY_W.
REQ-014 fill_beat_valid  in  1; fill_beat_data  in  BEAT_W.
REQ-015 fill_busy  out  1; fill_done  out  1  one-cycle pulse.
REQ-016 rd_perr  out  1  parity error on the returned line.

Function
REQ-017 Read: rd_en at edge N; rd_data and rd_valid reflect the addressed line after edge N. rd_valid is low after any edge with rd_en low; rd_data holds its last value.
REQ-018 CPU write: when wr_ready=1, each byte i with wr_mask[i]=1 is written at the edge; other bytes unchanged. When wr_ready=0, the write is dropped.
REQ-019 Same-edge read and write, same index and way: rd_data returns new data for masked bytes and old data elsewhere (write-first, per byte).
REQ-020 FSM states IDLE and FILL; reset to IDLE.
REQ-021 In IDLE, fill_start latches fill_index and fill_way, clears the beat counter and enters FILL.
REQ-022 In FILL, fill_start is ignored and fill_busy=1.
REQ-023 In FILL, each edge with fill_beat_valid=1 writes fill_beat_data to bits [cnt*BEAT_W +: BEAT_W] of the latched line, then increments cnt.
REQ-024 Beats arriving in non-consecutive cycles are allowed.
REQ-025 Beat accepted at cnt=BEATS-1: next state IDLE, cnt wraps to 0, fill_done=1 for exactly the following cycle.
REQ-026 Same-edge read of the line receiving a fill beat: write-first for that beat's bytes.
REQ-027 fill_beat_valid in IDLE is ignored.

Reset
REQ-028 rst clears all stored lines to 0, all parity bits to 0, state to IDLE, cnt to 0, rd_data to 0, and rd_valid, fill_done and rd_perr to 0.
REQ-029 rst during FILL aborts the fill with no fill_done; a partially filled line is zeroed by the array clear.
REQ-030 rst overrides all same-cycle requests.

Configuration
REQ-031 Macro DATA_ARRAY_PARITY_EN defined: one even-parity bit is stored per byte and computed on every byte write (CPU or fill).
REQ-032 With DATA_ARRAY_PARITY_EN, rd_perr is registered alongside rd_data and is the OR of per-byte parity mismatches.
REQ-033 With DATA_ARRAY_PARITY_EN, input par_flip (1 bit) inverts the stored parity of bytes written that cycle, for test.
REQ-034 Macro undefined: no parity storage, no par_flip port, rd_perr tied to 0.

Structure
REQ-035 Package data_array_pkg holds fill_state_t (IDLE, FILL) and the width helper functions for LINE_W, MASK_W and BEATS.
REQ-036 Sub-module way_bank: one way's NUM_SETS x LINE_W storage with byte-enable write port and synchronous clear; instantiated NUM_WAYS times.

Verification
REQ-037 Reset, then read set 3 way 1 -> rd_valid=1 next cycle, rd_data=0, rd_perr=0.
REQ-038 Write mask 0x0000000F, data all 0xAA, set 2 way 0, then read -> bytes 0-3 are 0xAA and the rest 0.
REQ-039 Write full line 0x11.. to set 5 way 1 while reading it in the same cycle -> rd_data=0x11.. next cycle.
REQ-040 fill_start set 7 way 1, then 4 beats 0xA..D with a 2-cycle gap after beat 1 -> fill_done pulses once after beat 4, wr_ready low throughout the fill, then a read returns the beats in order.
REQ-041 rst asserted after 2 fill beats -> fill_busy=0, no fill_done, line reads 0.
REQ-042 With DATA_ARRAY_PARITY_EN: write with par_flip=1 then read -> rd_perr=1; rewrite with par_flip=0 -> rd_perr=0.
